// File: rtl/Types.sv
// Shared execute-stage types: ALU opcodes and operand-select codes.
// Imported by the ALU and the execute stage.
package Types;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0,
    ALU_SUB   = 4'h1,
    ALU_AND   = 4'h2,
    ALU_OR    = 4'h3,
    ALU_XOR   = 4'h4,
    ALU_SLL   = 4'h5,
    ALU_SRL   = 4'h6,
    ALU_SRA   = 4'h7,
    ALU_SLT   = 4'h8,
    ALU_SLTU  = 4'h9,
    ALU_PASSB = 4'hA
  } AluOp;

  localparam logic SEL_A_REG = 1'b0;
  localparam logic SEL_A_PC  = 1'b1;
  localparam logic SEL_B_REG = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;

endpackage

// File: rtl/Alu.sv
// Combinational integer ALU, modulo 2^WIDTH.
// Codes outside the AluOp set produce zero.
module Alu
  import Types::*;
#(
  parameter int WIDTH = 32
) (
  input  AluOp             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] shamt;
  logic           lt_s;
  logic           lt_u;

  assign shamt = b[SHW-1:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  // Opcode decode; unlisted encodings fall to zero
  always_comb begin
    result = '0;
    unique case (op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_SLL:   result = a << shamt;
      ALU_SRL:   result = a >> shamt;
      ALU_SRA:   result = WIDTH'($signed(a) >>> shamt);
      ALU_SLT:   result = {{(WIDTH-1){1'b0}}, lt_s};
      ALU_SLTU:  result = {{(WIDTH-1){1'b0}}, lt_u};
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand select, ALU, one-entry output register.
// Define RV_EXEC_FORWARD_EN to forward o_Result into register operands.
module execute_stage
  import Types::*;
#(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
) (
  input  logic                i_Clock,
  input  logic                i_Reset,
  input  logic                i_Valid,
  output logic                o_Ready,
  input  AluOp                i_Op,
  input  logic [WIDTH-1:0]    i_DataA,
  input  logic [WIDTH-1:0]    i_DataB,
  input  logic [WIDTH-1:0]    i_Imm,
  input  logic [WIDTH-1:0]    i_PC,
  input  logic                i_SelA,
  input  logic                i_SelB,
  input  logic [REG_BITS-1:0] i_RsA,
  input  logic [REG_BITS-1:0] i_RsB,
  input  logic [REG_BITS-1:0] i_Rd,
  input  logic                i_RegWr,
  input  logic                i_Flush,
  input  logic                i_Ready,
  output logic                o_Valid,
  output logic [WIDTH-1:0]    o_Result,
  output logic [REG_BITS-1:0] o_Rd,
  output logic                o_RegWr,
  output logic [31:0]         o_OpCount
);

  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_result;
  logic [31:0]      op_count;
  logic             accept;

  assign o_Ready   = (!o_Valid || i_Ready) && !i_Flush;
  assign accept    = i_Valid && o_Ready;
  assign o_OpCount = op_count;

`ifdef RV_EXEC_FORWARD_EN
  logic fwd_a;
  logic fwd_b;

  assign fwd_a = o_Valid && o_RegWr &&
                 (o_Rd == i_RsA) && (i_RsA != '0);
  assign fwd_b = o_Valid && o_RegWr &&
                 (o_Rd == i_RsB) && (i_RsB != '0);
  assign reg_a = fwd_a ? o_Result : i_DataA;
  assign reg_b = fwd_b ? o_Result : i_DataB;
`else
  logic unused_rs;

  assign unused_rs = ^{i_RsA, i_RsB};
  assign reg_a     = i_DataA;
  assign reg_b     = i_DataB;
`endif

  assign op_a = (i_SelA == SEL_A_PC)  ? i_PC  : reg_a;
  assign op_b = (i_SelB == SEL_B_IMM) ? i_Imm : reg_b;

  Alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .op    (i_Op),
    .a     (op_a),
    .b     (op_b),
    .result(alu_result)
  );

  // Output register: flush beats accept, accept beats drain, else hold
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      o_Valid  <= 1'b0;
      o_Result <= '0;
      o_Rd     <= '0;
      o_RegWr  <= 1'b0;
      op_count <= '0;
    end else if (i_Flush) begin
      o_Valid <= 1'b0;
      o_RegWr <= 1'b0;
    end else if (accept) begin
      o_Valid  <= 1'b1;
      o_Result <= alu_result;
      o_Rd     <= i_Rd;
      o_RegWr  <= i_RegWr;
      op_count <= op_count + 32'd1;
    end else if (i_Ready) begin
      o_Valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with hand-computed vectors.
// Expected forwarding result follows RV_EXEC_FORWARD_EN.
module tb_execute_stage;
  import Types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  AluOp        i_op;
  logic [31:0] i_data_a, i_data_b, i_imm, i_pc;
  logic        i_sel_a, i_sel_b;
  logic [4:0]  i_rs_a, i_rs_b, i_rd;
  logic        i_reg_wr, i_flush, i_ready;
  logic        o_valid;
  logic [31:0] o_result;
  logic [4:0]  o_rd;
  logic        o_reg_wr;
  logic [31:0] o_op_count;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_cnt = 0;

  always #5 clk = ~clk;

  execute_stage #(.WIDTH(32), .REG_BITS(5)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Valid(i_valid),
    .o_Ready(o_ready), .i_Op(i_op),
    .i_DataA(i_data_a), .i_DataB(i_data_b),
    .i_Imm(i_imm), .i_PC(i_pc),
    .i_SelA(i_sel_a), .i_SelB(i_sel_b),
    .i_RsA(i_rs_a), .i_RsB(i_rs_b), .i_Rd(i_rd),
    .i_RegWr(i_reg_wr), .i_Flush(i_flush), .i_Ready(i_ready),
    .o_Valid(o_valid), .o_Result(o_result), .o_Rd(o_rd),
    .o_RegWr(o_reg_wr), .o_OpCount(o_op_count)
  );

  task automatic set_op(input AluOp op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic wr);
    i_valid = 1'b1; i_op = op; i_data_a = a; i_data_b = b;
    i_sel_a = SEL_A_REG; i_sel_b = SEL_B_REG;
    i_rs_a = 5'd0; i_rs_b = 5'd0; i_rd = rd; i_reg_wr = wr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_flush = 1'b0; i_ready = 1'b1;
    i_imm = 0; i_pc = 0;
    set_op(ALU_ADD, 32'd1, 32'd2, 5'd1, 1'b1);
    #1;
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %0b want 0", o_valid); end
    vectors++; if (o_result !== 32'd0) begin miscompares++; $display("FAIL rst_result got %h want 0", o_result); end
    vectors++; if (o_op_count !== 32'd0) begin miscompares++; $display("FAIL rst_count got %h want 0", o_op_count); end
    vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %0b want 1", o_ready); end
    tick();
    vectors++; if (o_valid !== 1'b0 || o_op_count !== 32'd0) begin miscompares++; $display("FAIL rst_noaccept got v=%0b c=%h want v=0 c=0", o_valid, o_op_count); end
    rst = 1'b0; i_valid = 1'b0;
    tick();
  endtask

  task automatic test_add();
    set_op(ALU_ADD, 32'd5, 32'd7, 5'd9, 1'b1);
    tick(); exp_cnt++;
    i_valid = 1'b0;
    vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL add_valid got %0b want 1", o_valid); end
    vectors++; if (o_result !== 32'd12) begin miscompares++; $display("FAIL add_result got %h want 0000000c", o_result); end
    vectors++; if (o_op_count !== exp_cnt) begin miscompares++; $display("FAIL add_count got %h want %h", o_op_count, exp_cnt); end
    vectors++; if (o_rd !== 5'd9 || o_reg_wr !== 1'b1) begin miscompares++; $display("FAIL add_rd got %0d/%0b want 9/1", o_rd, o_reg_wr); end
  endtask

  task automatic test_back_to_back();
    AluOp        ops [11];
    logic [31:0] av  [11];
    logic [31:0] bv  [11];
    logic [31:0] ev  [11];
    ops = '{ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL,
            ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASSB, AluOp'(4'hF)};
    av  = '{32'd3, 32'hF0F0_00FF, 32'hF000_0000, 32'hFFFF_0000,
            32'd1, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
            32'hFFFF_FFFF, 32'd0, 32'd9};
    bv  = '{32'd5, 32'h0FF0_0F0F, 32'h0000_000F, 32'h0FF0_0FF0,
            32'd36, 32'd4, 32'd4, 32'd1, 32'd1, 32'h1234_5678, 32'd9};
    ev  = '{32'hFFFF_FFFE, 32'h00F0_000F, 32'hF000_000F,
            32'hF00F_0FF0, 32'd16, 32'h0800_0000, 32'hF800_0000,
            32'd1, 32'd0, 32'h1234_5678, 32'd0};
    for (int k = 0; k < 11; k++) begin
      set_op(ops[k], av[k], bv[k], 5'd2, 1'b1);
      tick(); exp_cnt++;
      vectors++; if (o_result !== ev[k] || o_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_%0d got %h v=%0b want %h v=1", k, o_result, o_valid, ev[k]); end
    end
    i_valid = 1'b0;
    vectors++; if (o_op_count !== exp_cnt) begin miscompares++; $display("FAIL b2b_count got %h want %h", o_op_count, exp_cnt); end
    tick();
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL drain_valid got %0b want 0", o_valid); end
  endtask

  task automatic test_stall();
    set_op(ALU_SUB, 32'd77, 32'd66, 5'd6, 1'b1);
    i_sel_a = SEL_A_PC; i_pc = 32'h100;
    i_sel_b = SEL_B_IMM; i_imm = 32'd4;
    i_ready = 1'b0;
    tick(); exp_cnt++;
    set_op(ALU_ADD, 32'd1, 32'd1, 5'd7, 1'b0);
    for (int k = 0; k < 3; k++) begin
      vectors++; if (o_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready_%0d got %0b want 0", k, o_ready); end
      vectors++; if (o_result !== 32'hFC || o_valid !== 1'b1 || o_rd !== 5'd6) begin miscompares++; $display("FAIL stall_hold_%0d got %h v=%0b rd=%0d want fc v=1 rd=6", k, o_result, o_valid, o_rd); end
      tick();
    end
    vectors++; if (o_op_count !== exp_cnt) begin miscompares++; $display("FAIL stall_count got %h want %h", o_op_count, exp_cnt); end
    i_valid = 1'b0; i_ready = 1'b1;
    tick();
    vectors++; if (o_valid !== 1'b0 || o_result !== 32'hFC) begin miscompares++; $display("FAIL stall_drain got v=%0b %h want v=0 fc", o_valid, o_result); end
  endtask

  task automatic test_flush();
    set_op(ALU_ADD, 32'd1, 32'd1, 5'd3, 1'b1);
    tick(); exp_cnt++;
    set_op(ALU_ADD, 32'd4, 32'd4, 5'd5, 1'b1);
    i_flush = 1'b1;
    #1;
    vectors++; if (o_ready !== 1'b0) begin miscompares++; $display("FAIL flush_ready got %0b want 0", o_ready); end
    tick();
    i_flush = 1'b0; i_valid = 1'b0;
    vectors++; if (o_valid !== 1'b0 || o_reg_wr !== 1'b0) begin miscompares++; $display("FAIL flush_clear got v=%0b wr=%0b want 0/0", o_valid, o_reg_wr); end
    vectors++; if (o_op_count !== exp_cnt) begin miscompares++; $display("FAIL flush_count got %h want %h", o_op_count, exp_cnt); end
  endtask

  task automatic test_forward();
    logic [31:0] want;
`ifdef RV_EXEC_FORWARD_EN
    want = 32'd15;
`else
    want = 32'd10;
`endif
    set_op(ALU_ADD, 32'd2, 32'd3, 5'd3, 1'b1);
    tick(); exp_cnt++;
    set_op(ALU_ADD, 32'd0, 32'd10, 5'd4, 1'b1);
    i_rs_a = 5'd3;
    tick(); exp_cnt++;
    i_valid = 1'b0;
    vectors++; if (o_result !== want) begin miscompares++; $display("FAIL forward got %0d want %0d", o_result, want); end
    tick();
  endtask

  task automatic test_wrap();
    force dut.op_count = 32'hFFFF_FFFF;
    #1;
    release dut.op_count;
    set_op(ALU_ADD, 32'd1, 32'd2, 5'd1, 1'b1);
    tick(); exp_cnt = 32'd0;
    i_valid = 1'b0;
    vectors++; if (o_op_count !== exp_cnt) begin miscompares++; $display("FAIL wrap got %h want 00000000", o_op_count); end
  endtask

  task automatic test_async_reset();
    set_op(ALU_ADD, 32'd20, 32'd22, 5'd8, 1'b1);
    i_ready = 1'b0;
    tick();
    i_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (o_valid !== 1'b0 || o_reg_wr !== 1'b0) begin miscompares++; $display("FAIL areset_ctl got v=%0b wr=%0b want 0/0", o_valid, o_reg_wr); end
    vectors++; if (o_result !== 32'd0 || o_rd !== 5'd0 || o_op_count !== 32'd0) begin miscompares++; $display("FAIL areset_data got %h rd=%0d c=%h want 0", o_result, o_rd, o_op_count); end
    #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_stall();
    test_flush();
    test_forward();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning datapath width in bits.
REQ-002 The block SHALL have parameter REG_BITS, default 5, meaning register-index width.
REQ-003 Port i_Clock SHALL be: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 Port i_Reset SHALL be: input, 1 bit, asynchronous, active-high reset.
REQ-005 Port i_Valid SHALL be: input, 1 bit, upstream operation valid.
REQ-006 Port o_Ready SHALL be: output, 1 bit, stage can accept an operation this cycle.
REQ-007 Port i_Op SHALL be: input, Types::AluOp, ALU operation.
REQ-008 Ports i_DataA / i_DataB SHALL be: input, WIDTH each, register-file read values.
REQ-009 Ports i_Imm / i_PC SHALL be: input, WIDTH each, immediate and instruction address.
REQ-010 Ports i_SelA / i_SelB SHALL be: input, 1 bit each; SelA 1 = PC, SelB 1 = Imm, 0 = register.
REQ-011 Ports i_RsA / i_RsB / i_Rd SHALL be: input, REG_BITS each, source and destination indices.
REQ-012 Port i_RegWr SHALL be: input, 1 bit, operation writes i_Rd.
REQ-013 Port i_Flush SHALL be: input, 1 bit, discard held and incoming operation.
REQ-014 Port i_Ready SHALL be: input, 1 bit, downstream accepts the output.
REQ-015 Ports o_Valid (1), o_Result (WIDTH), o_Rd (REG_BITS), o_RegWr (1) SHALL be outputs forming the registered result.
REQ-016 Port o_OpCount SHALL be: output, 32 bits, count of accepted operations.

Function
REQ-017 o_Ready SHALL equal (!o_Valid || i_Ready) && !i_Flush, combinationally.
REQ-018 An operation SHALL be accepted on a rising edge where i_Valid && o_Ready.
REQ-019 On acceptance, o_Result SHALL load the ALU result of the selected operands, with o_Rd/o_RegWr from i_Rd/i_RegWr, and o_Valid set to 1; latency is one cycle.
REQ-020 With o_Valid=1 and i_Ready=0, all outputs SHALL hold unchanged (stall).
REQ-021 With o_Valid=1, i_Ready=1 and no acceptance, o_Valid SHALL clear next edge.
REQ-022 i_Flush=1 SHALL clear o_Valid and o_RegWr next edge, override acceptance, and leave o_OpCount unchanged.
REQ-023 ALU arithmetic SHALL be modulo 2^WIDTH; SLT/SLTU yield 1 or 0, unsupported opcodes yield 0.
REQ-024 o_OpCount SHALL increment by 1 per acceptance and wrap from 0xFFFFFFFF to 0.

Reset
REQ-025 Asserting i_Reset SHALL immediately clear o_Valid, o_Result, o_Rd, o_RegWr and o_OpCount to 0, including mid-stall.
REQ-026 o_Ready SHALL be 1 during reset when i_Flush=0; no operation SHALL be accepted while i_Reset=1.

Configuration
REQ-027 Macro RV_EXEC_FORWARD_EN SHALL gate EX->EX operand forwarding.
REQ-028 With it defined, a register operand SHALL take o_Result instead of i_DataA/i_DataB when o_Valid && o_RegWr && o_Rd == Rs && Rs != 0.
REQ-029 Without it, register operands SHALL always come from i_DataA/i_DataB, with no extra logic.

Structure
REQ-030 AluOp and operand-select constants SHALL reside in the shared Types package.
REQ-031 Operand muxing and forwarding SHALL be local; the arithmetic SHALL be one instance of Alu.

Verification
REQ-032 ADD with DataA=5, DataB=7, SelA=SelB=0, i_Ready=1 -> next cycle o_Valid=1, o_Result=12, o_OpCount=1.
REQ-033 SUB with SelA=1, PC=0x100, SelB=1, Imm=4, i_Ready=0 for 3 cycles -> o_Result=0xFC held, o_Ready=0 throughout.
REQ-034 Accept ADD 1+1 to Rd=3, i_Flush=1 on the next cycle -> o_Valid=0, o_RegWr=0, o_OpCount=1.
REQ-035 With RV_EXEC_FORWARD_EN, ADD x3=2+3, then ADD RsA=3, DataA=0 (stale), DataB=10 -> second o_Result=15; without the macro, 10.
REQ-036 Preload o_OpCount to 0xFFFFFFFF via accepted operations, then one more -> o_OpCount=0.
REQ-037 Assert i_Reset asynchronously mid-stall -> all outputs 0 before the next clock edge.
